// File: rtl/preset_timer.sv
// Preset countdown/countup timer with pause toggle, reload and terminal-count pulse.
// Optional feature: define PRESET_TIMER_AUTORELOAD_EN to restart from the preset after each terminal count.
module preset_timer #(
  parameter int WIDTH    = 5,
  parameter int PRESET_A = 24,
  parameter int PRESET_B = 30,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             dir,
  input  logic             load,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             tc_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_PAUSE, S_EXP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_sync;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic             r_tc;

  logic [WIDTH-1:0] w_ld_limit;
  logic [WIDTH-1:0] w_ld_start;
  logic [WIDTH-1:0] w_ld_term;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next_cnt;
  logic             w_hit;
  logic             w_tick;
  logic             w_press;
  logic             w_term_evt;

  // Falling edge seen two flops deep: the toggle lands on the 3rd low sample.
  assign w_press    = r_sync[2] & ~r_sync[1];
  assign w_tick     = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));

  assign w_ld_limit = sel ? WIDTH'(PRESET_B) : WIDTH'(PRESET_A);
  assign w_ld_start = dir ? '0 : w_ld_limit;
  assign w_ld_term  = dir ? w_ld_limit : '0;
  assign w_term     = r_dir ? r_limit : '0;
  assign w_step     = r_dir ? r_count + WIDTH'(1) : r_count - WIDTH'(1);

`ifdef PRESET_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] w_start;
  logic             w_wrap;
  localparam bit TC_HALTS = 1'b0;
  assign w_start    = r_dir ? '0 : r_limit;
  assign w_wrap     = (r_count == w_term);
  assign w_next_cnt = w_wrap ? w_start : w_step;
  assign w_hit      = !w_wrap && (w_step == w_term);
`else
  localparam bit TC_HALTS = 1'b1;
  assign w_next_cnt = w_step;
  assign w_hit      = (w_step == w_term);
`endif

  assign w_term_evt = w_tick && w_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Priority: load, then terminal event, then pause toggle.
  always_comb begin
    w_next = r_state;
    if (load) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  w_next = (w_ld_start == w_ld_term) ? S_EXP : S_RUN;
        S_RUN: begin
          if (w_term_evt)   w_next = TC_HALTS ? S_EXP : S_RUN;
          else if (w_press) w_next = S_PAUSE;
        end
        S_PAUSE: if (w_press) w_next = S_RUN;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    running = (r_state == S_RUN);
    done    = (r_state == S_EXP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], pause};
  end

  // A pending reload freezes the count so the next LOAD starts from a clean state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_limit <= '0;
      r_dir   <= 1'b0;
      r_presc <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_limit <= w_ld_limit;
          r_dir   <= dir;
          r_count <= w_ld_start;
          r_presc <= '0;
          r_tc    <= !load && (w_ld_start == w_ld_term);
        end
        S_RUN: begin
          if (!load) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              r_count <= w_next_cnt;
              r_tc    <= w_hit;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign count    = r_count;
  assign tc_pulse = r_tc;

endmodule

// File: tb/tb_preset_timer.sv
// Bench for preset_timer: two instances (default presets; PRESET_A=0 with TICK_DIV=4) share stimulus,
// a cycle model feeds per-instance scoreboards, plus directed checks at key points.
module tb_preset_timer;

`ifdef PRESET_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sel = 1'b0, dir = 1'b0, load = 1'b0, pause = 1'b1;
  logic [4:0] cnt_a, cnt_b;
  logic       run_a, run_b, done_a, done_b, tc_a, tc_b;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int         st;
    int         cnt;
    int         presc;
    bit         tc;
    int         lim;
    bit         dr;
    logic [3:0] hist;
  } mstate_t;

  typedef struct {
    logic [4:0] cnt;
    logic       run;
    logic       dn;
    logic       tc;
  } exp_t;

  mstate_t ma, mb;
  exp_t    q_a[$], q_b[$];

  preset_timer u_a (
    .clk(clk), .reset(rst_n), .sel(sel), .dir(dir), .load(load), .pause(pause),
    .count(cnt_a), .running(run_a), .done(done_a), .tc_pulse(tc_a)
  );

  preset_timer #(.WIDTH(5), .PRESET_A(0), .PRESET_B(30), .TICK_DIV(4)) u_b (
    .clk(clk), .reset(rst_n), .sel(sel), .dir(dir), .load(load), .pause(pause),
    .count(cnt_b), .running(run_b), .done(done_b), .tc_pulse(tc_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic mstate_t mreset();
    mstate_t m;
    m.st = 0; m.cnt = 0; m.presc = 0; m.tc = 0; m.lim = 0; m.dr = 0; m.hist = 4'hF;
    return m;
  endfunction

  // Behavioural reference: a press is three consecutive low samples after a high one.
  function automatic mstate_t mstep(input mstate_t m, input int pa, input int pb, input int div,
                                    input logic s, input logic d, input logic ld, input logic pz);
    mstate_t n;
    int      term, start;
    bit      tick, hit, press;
    n      = m;
    n.tc   = 0;
    n.hist = {m.hist[2:0], pz};
    press  = (n.hist == 4'b1000);
    term   = m.dr ? m.lim : 0;
    start  = m.dr ? 0 : m.lim;
    hit    = 0;
    case (m.st)
      0: begin
        n.lim   = s ? pb : pa;
        n.dr    = d;
        n.cnt   = d ? 0 : n.lim;
        n.presc = 0;
        if (ld) n.st = 0;
        else if (n.cnt == (d ? n.lim : 0)) begin n.st = 3; n.tc = 1; end
        else n.st = 1;
      end
      1: begin
        if (ld) n.st = 0;
        else begin
          tick    = (m.presc == div - 1);
          n.presc = tick ? 0 : m.presc + 1;
          if (tick) begin
            if (AR && m.cnt == term) n.cnt = start;
            else begin
              n.cnt = m.dr ? m.cnt + 1 : m.cnt - 1;
              hit   = (n.cnt == term);
            end
            n.tc = hit;
          end
          if (tick && hit) n.st = AR ? 1 : 3;
          else if (press)  n.st = 2;
        end
      end
      2: if (ld) n.st = 0; else if (press) n.st = 1;
      default: if (ld) n.st = 0;
    endcase
    return n;
  endfunction

  function automatic exp_t toexp(input mstate_t m);
    exp_t e;
    e.cnt = 5'(m.cnt);
    e.run = (m.st == 1);
    e.dn  = (m.st == 3);
    e.tc  = m.tc;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    exp_t ea, eb;
    @(posedge clk);
    ma = mstep(ma, 24, 30, 1, sel, dir, load, pause);
    mb = mstep(mb, 0, 30, 4, sel, dir, load, pause);
    q_a.push_back(toexp(ma));
    q_b.push_back(toexp(mb));
    @(negedge clk);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk("a_count",   32'(cnt_a),  32'(ea.cnt));
    chk("a_running", 32'(run_a),  32'(ea.run));
    chk("a_done",    32'(done_a), 32'(ea.dn));
    chk("a_tc",      32'(tc_a),   32'(ea.tc));
    chk("b_count",   32'(cnt_b),  32'(eb.cnt));
    chk("b_running", 32'(run_b),  32'(eb.run));
    chk("b_done",    32'(done_b), 32'(eb.dn));
    chk("b_tc",      32'(tc_b),   32'(eb.tc));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_count"}, 32'(cnt_a), 0);
    chk({tag, "_a_run"},   32'(run_a), 0);
    chk({tag, "_a_done"},  32'(done_a), 0);
    chk({tag, "_a_tc"},    32'(tc_a), 0);
    chk({tag, "_b_count"}, 32'(cnt_b), 0);
    chk({tag, "_b_run"},   32'(run_b), 0);
    chk({tag, "_b_done"},  32'(done_b), 0);
    chk({tag, "_b_tc"},    32'(tc_b), 0);
  endtask

  initial begin
    int         n;
    logic [4:0] frozen;

    ma = mreset();
    mb = mreset();

    // Power-up reset
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // First edge executes LOAD: a counts down from 24, b (PRESET_A=0) expires at once
    cycle();
    chk("first_load_count", 32'(cnt_a), 24);
    chk("first_load_run",   32'(run_a), 1);
    chk("zero_preset_done", 32'(done_b), 1);
    chk("zero_preset_tc",   32'(tc_b), 1);
    cycles(24);
    chk("down_end_count", 32'(cnt_a), 0);
    chk("down_end_tc",    32'(tc_a), 1);
    chk("down_end_done",  32'(done_a), 1);
    cycles(3);
    chk("done_holds", 32'(done_a), 1);

    // Press while expired: ignored
    pause = 1'b0; cycles(5);
    pause = 1'b1; cycles(5);
    chk("exp_press_done", 32'(done_a), 1);

    // Reload and pause at count 20
    load = 1'b1; cycle();
    load = 1'b0; cycle();
    n = 0;
    while (cnt_a != 5'd20 && n < 40) begin cycle(); n++; end
    chk("reach20", 32'(cnt_a), 20);
    pause = 1'b0; cycles(3);
    chk("paused_run", 32'(run_a), 0);
    frozen = cnt_a;
    cycles(3);
    chk("paused_frozen", 32'(cnt_a), 32'(frozen));
    pause = 1'b1; cycles(4);
    pause = 1'b0; cycles(3);
    chk("resumed_run", 32'(run_a), 1);
    pause = 1'b1;
    n = 0;
    while (!done_a && n < 40) begin cycle(); n++; end
    chk("down2_done", 32'(done_a), 1);

    // Up count, sel=1, TICK_DIV=4 on b: 120 cycles from LOAD to terminal
    sel = 1'b1; dir = 1'b1;
    load = 1'b1; cycle();
    load = 1'b0; cycle();
    chk("up_start_count", 32'(cnt_b), 0);
    chk("up_start_run",   32'(run_b), 1);
    n = 0;
    while (n < 200) begin
      cycle(); n++;
      if (tc_b) break;
    end
    chk("up_len",   n, 120);
    chk("up_count", 32'(cnt_b), 30);
    chk("up_done",  32'(done_a), 1);

    // Up count with pause mid-phase; prescaler phase preserved across pause
    load = 1'b1; cycle();
    load = 1'b0; cycle();
    n = 0;
    while (cnt_b != 5'd5 && n < 60) begin cycle(); n++; end
    cycles(1);
    pause = 1'b0; cycles(4);
    chk("up_paused", 32'(run_b), 0);
    frozen = cnt_b;
    pause = 1'b1; cycles(6);
    chk("up_frozen", 32'(cnt_b), 32'(frozen));
    pause = 1'b0; cycles(4);
    pause = 1'b1; cycles(30);

    // Load at count 10 coinciding with a pause press; sel toggled
    sel = 1'b0; dir = 1'b0;
    load = 1'b1; cycle();
    load = 1'b0; cycle();
    n = 0;
    while (cnt_a != 5'd12 && n < 40) begin cycle(); n++; end
    pause = 1'b0; cycles(2);
    sel = 1'b1; load = 1'b1; cycle();
    chk("ld_state_run", 32'(run_a), 0);
    chk("ld_frozen",    32'(cnt_a), 10);
    load = 1'b0; cycle();
    chk("ld_new_count", 32'(cnt_a), 30);
    chk("ld_new_run",   32'(run_a), 1);
    cycles(3);
    pause = 1'b1; cycles(5);
    chk("ld_press_dropped", 32'(run_a), 1);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    ma = mreset();
    mb = mreset();
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
